// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic HOST_RD = 1'b0;
    localparam logic HOST_WR = 1'b1;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating RUN-cycle counter with clear/enable and a watchdog terminal match.
module run_cycle_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned          CNT_W     = 16,
    parameter logic [CNT_W-1:0]     WDT_LIMIT = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_o
);

    // Terminal is one below the limit: the matching cycle is the last counted RUN cycle.
    localparam logic [CNT_W-1:0] WDT_TERM = WDT_LIMIT - {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;

    // Clear wins over enable; counting stops at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == WDT_TERM);

endmodule

// File: rtl/cpu_run_controller.sv
// Run control (IDLE/RUN/HALTED), watchdog and host/core data memory arbitration.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      ADDR_W    = 32,
    parameter int unsigned      CNT_W     = 16,
    parameter logic [CNT_W-1:0] WDT_LIMIT = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Stop,
    input  logic              HostValid,
    output logic              HostReady,
    input  logic              HostWrite,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostWData,
    output logic              HostRValid,
    output logic [DATA_W-1:0] HostRData,
    input  logic              CoreHalt,
    input  logic              CoreMemRead_en,
    input  logic              CoreMemWrite_en,
    input  logic [ADDR_W-1:0] CoreAddr,
    input  logic [DATA_W-1:0] CoreWData,
    output logic              CoreRun,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemRead_en,
    output logic              MemWrite_en,
    input  logic [DATA_W-1:0] MemRData,
    output logic              Halt,
    output logic              Timeout,
    output logic [CNT_W-1:0]  CycleCount
);

    state_e            state_q, state_d;
    logic              timeout_q, timeout_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wdt_term;
    logic              start_go;
    logic              host_acc;
    logic              host_rd;
    logic              host_wr;
    logic              in_run;

    assign in_run    = (state_q == ST_RUN);
    assign CoreRun   = in_run;
    assign Halt      = (state_q == ST_HALTED);
    assign HostReady = !in_run && !Start;
    assign host_acc  = HostValid && HostReady;
    assign host_rd   = host_acc && (HostWrite == HOST_RD);
    assign host_wr   = host_acc && (HostWrite == HOST_WR);

    // Core owns the memory while running; the host owns it otherwise.
    always_comb begin
        if (in_run) begin
            MemAddr     = CoreAddr;
            MemWData    = CoreWData;
            MemRead_en  = CoreMemRead_en && CoreRun;
            MemWrite_en = CoreMemWrite_en && CoreRun;
        end else begin
            MemAddr     = HostAddr;
            MemWData    = HostWData;
            MemRead_en  = host_rd;
            MemWrite_en = host_wr;
        end
    end

    // Next-state logic; Stop has priority over every other request.
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        start_go  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    state_d   = ST_RUN;
                    timeout_d = 1'b0;
                    start_go  = 1'b1;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else if (CoreHalt) begin
                    state_d = ST_HALTED;
                end else if (wdt_term) begin
                    state_d   = ST_HALTED;
                    timeout_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else if (Start) begin
                    state_d   = ST_RUN;
                    timeout_d = 1'b0;
                    start_go  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, sticky timeout and the one-cycle host read response.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
            rvalid_q  <= host_rd;
            if (host_rd) begin
                rdata_q <= MemRData;
            end
        end
    end

    run_cycle_counter #(
        .CNT_W     (CNT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_cycle_cnt (
        .clk_i   (CLK),
        .rst_ni  (Reset_n),
        .clr_i   (start_go),
        .en_i    (in_run),
        .count_o (CycleCount),
        .term_o  (wdt_term)
    );

    assign HostRValid = rvalid_q;
    assign HostRData  = rdata_q;
    assign Timeout    = timeout_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] WDT = 16'd8;

    logic              CLK = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Start = 1'b0, Stop = 1'b0;
    logic              HostValid = 1'b0, HostWrite = 1'b0;
    logic [ADDR_W-1:0] HostAddr = '0;
    logic [DATA_W-1:0] HostWData = '0;
    logic              HostReady, HostRValid;
    logic [DATA_W-1:0] HostRData;
    logic              CoreHalt = 1'b0, CoreMemRead_en = 1'b0, CoreMemWrite_en = 1'b0;
    logic [ADDR_W-1:0] CoreAddr = '0;
    logic [DATA_W-1:0] CoreWData = '0;
    logic              CoreRun;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData, MemRData;
    logic              MemRead_en, MemWrite_en;
    logic              Halt, Timeout;
    logic [CNT_W-1:0]  CycleCount;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    cpu_run_controller #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .WDT_LIMIT(WDT)
    ) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Stop(Stop),
        .HostValid(HostValid), .HostReady(HostReady), .HostWrite(HostWrite),
        .HostAddr(HostAddr), .HostWData(HostWData),
        .HostRValid(HostRValid), .HostRData(HostRData),
        .CoreHalt(CoreHalt), .CoreMemRead_en(CoreMemRead_en),
        .CoreMemWrite_en(CoreMemWrite_en), .CoreAddr(CoreAddr), .CoreWData(CoreWData),
        .CoreRun(CoreRun), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRead_en(MemRead_en), .MemWrite_en(MemWrite_en), .MemRData(MemRData),
        .Halt(Halt), .Timeout(Timeout), .CycleCount(CycleCount)
    );

    // Behavioural data memory: combinational read, write on the clock edge.
    assign MemRData = mem[MemAddr[7:0]];
    always @(posedge CLK) if (MemWrite_en) mem[MemAddr[7:0]] <= MemWData;

    task automatic idle_inputs();
        Start = 0; Stop = 0; HostValid = 0; HostWrite = 0;
        CoreHalt = 0; CoreMemRead_en = 0; CoreMemWrite_en = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic pop_check(input string name);
        logic [DATA_W-1:0] e;
        n_vec++;
        if (!HostRValid) begin
            n_err++;
            $display("FAIL %s_rvalid: got 0 expected 1", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_sb: got rvalid expected none pending", name);
        end else begin
            e = exp_q.pop_front();
            if (HostRData !== e) begin
                n_err++;
                $display("FAIL %s_rdata: got %h expected %h", name, HostRData, e);
            end
        end
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge CLK);
        HostValid = 1; HostWrite = 1; HostAddr = a; HostWData = d;
        #1 chk("wr_memwrite_en", MemWrite_en, 1'b1);
        @(negedge CLK);
        HostValid = 0;
        #1 chk("wr_memwrite_idle", MemWrite_en, 1'b0);
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e, input string name);
        @(negedge CLK);
        HostValid = 1; HostWrite = 0; HostAddr = a;
        exp_q.push_back(e);
        #1 chk({name, "_rvalid_pre"}, HostRValid, 1'b0);
        @(posedge CLK); #1;
        HostValid = 0;
        pop_check(name);
        @(posedge CLK); #1;
        chk({name, "_rvalid_once"}, HostRValid, 1'b0);
    endtask

    task automatic start_run();
        @(negedge CLK);
        Start = 1;
        @(negedge CLK);
        Start = 0;
    endtask

    task automatic test_reset();
        Reset_n = 0;
        #12;
        chk("rst_hostready", HostReady, 1'b1);
        chk("rst_corerun", CoreRun, 1'b0);
        chk("rst_halt", Halt, 1'b0);
        chk("rst_rvalid", HostRValid, 1'b0);
        chk("rst_rdata", HostRData, '0);
        chk("rst_timeout", Timeout, 1'b0);
        chk("rst_count", CycleCount, '0);
        chk("rst_memwr", MemWrite_en, 1'b0);
        @(negedge CLK);
        Reset_n = 1;
    endtask

    task automatic test_host_rw();
        host_write(32'h10, 32'h1234ABCD);
        host_read(32'h10, 32'h1234ABCD, "rd10");
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] vals [4];
        vals[0] = 32'hA5A5_0001; vals[1] = 32'h0BAD_F00D;
        vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) host_write(32'h40 + i, vals[i]);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            HostValid = 1; HostWrite = 0; HostAddr = 32'h40 + i;
            exp_q.push_back(vals[i]);
            @(posedge CLK); #1;
            pop_check("b2b");
        end
        HostValid = 0;
        @(posedge CLK); #1;
        chk("b2b_rvalid_end", HostRValid, 1'b0);
    endtask

    task automatic test_halt();
        @(negedge CLK);
        Start = 1; HostValid = 1; HostWrite = 0; HostAddr = 32'h10;
        #1 chk("start_hostready", HostReady, 1'b0);
        chk("start_memrd", MemRead_en, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            Start = 0;
            #1 chk("run_hostready", HostReady, 1'b0);
            chk("run_corerun", CoreRun, 1'b1);
            if (k == 1) chk("run_first_rvalid", HostRValid, 1'b0);
            if (k == 5) CoreHalt = 1;
        end
        @(negedge CLK);
        idle_inputs();
        #1 chk("halt_halt", Halt, 1'b1);
        chk("halt_count", CycleCount, 16'd5);
        chk("halt_timeout", Timeout, 1'b0);
        chk("halt_hostready", HostReady, 1'b1);
        chk("halt_corerun", CoreRun, 1'b0);
        Stop = 1;
        @(negedge CLK);
        Stop = 0;
        #1 chk("halt_stop_halt", Halt, 1'b0);
        chk("halt_stop_count", CycleCount, 16'd5);
    endtask

    task automatic test_watchdog();
        int runs = 0;
        start_run();
        for (int i = 0; i < 40 && !Halt; i++) begin
            #1 if (CoreRun) runs++;
            @(negedge CLK);
        end
        #1 chk("wdt_halt", Halt, 1'b1);
        chk("wdt_runs", runs, 8);
        chk("wdt_timeout", Timeout, 1'b1);
        chk("wdt_count", CycleCount, 16'd8);
        Start = 1;
        @(negedge CLK);
        Start = 0;
        #1 chk("wdt_restart_timeout", Timeout, 1'b0);
        chk("wdt_restart_count", CycleCount, 16'd0);
        chk("wdt_restart_run", CoreRun, 1'b1);
        Stop = 1;
        @(negedge CLK);
        Stop = 0;
    endtask

    task automatic test_core_priority();
        start_run();
        CoreMemWrite_en = 1; CoreAddr = 32'h20; CoreWData = 32'd7;
        HostValid = 1; HostWrite = 1; HostAddr = 32'h20; HostWData = 32'd9;
        #1 chk("arb_hostready", HostReady, 1'b0);
        chk("arb_memaddr", MemAddr, 32'h20);
        chk("arb_memwdata", MemWData, 32'd7);
        chk("arb_memwr", MemWrite_en, 1'b1);
        @(negedge CLK);
        CoreMemWrite_en = 0; HostValid = 0; CoreHalt = 1;
        @(negedge CLK);
        CoreHalt = 0;
        chk("arb_mem20", mem[8'h20], 32'd7);
        host_read(32'h20, 32'd7, "rd20");
        Stop = 1;
        @(negedge CLK);
        Stop = 0;
    endtask

    task automatic test_stop_priority();
        start_run();
        Stop = 1; CoreHalt = 1;
        CoreMemWrite_en = 1; CoreAddr = 32'h30; CoreWData = 32'h55;
        @(negedge CLK);
        idle_inputs();
        #1 chk("stop_halt", Halt, 1'b0);
        chk("stop_corerun", CoreRun, 1'b0);
        chk("stop_hostready", HostReady, 1'b1);
        Start = 1; Stop = 1;
        @(negedge CLK);
        idle_inputs();
        #1 chk("startstop_corerun", CoreRun, 1'b0);
        chk("startstop_halt", Halt, 1'b0);
        host_read(32'h30, 32'h55, "rd30");
    endtask

    task automatic test_async_reset();
        start_run();
        @(negedge CLK);
        @(negedge CLK);
        #1 chk("ar_pre_corerun", CoreRun, 1'b1);
        chk("ar_pre_count", CycleCount, 16'd2);
        #1 Reset_n = 0;
        #1 chk("ar_corerun", CoreRun, 1'b0);
        chk("ar_count", CycleCount, 16'd0);
        chk("ar_hostready", HostReady, 1'b1);
        chk("ar_halt", Halt, 1'b0);
        @(negedge CLK);
        Reset_n = 1;
        host_read(32'h10, 32'h1234ABCD, "ar_rd10");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_host_rw();
        test_back_to_back();
        test_halt();
        test_watchdog();
        test_core_priority();
        test_stop_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
